// File: rtl/method_call_arbiter_if.sv
// method_call_arbiter_if: bundles the client-side call bus and the downstream
// method port (<method>_req / _busy / _return plus argument) of one shared method.
//   slave  : seen by the arbiter (takes client requests, drives m_req/m_arg)
//   master : seen by whoever drives clients and models the downstream method
// Client i owns bit i of cli_req/cli_busy/cli_done and cli_arg[i*ARG_W +: ARG_W].
interface method_call_arbiter_if #(
  parameter int N     = 4,
  parameter int ARG_W = 32,
  parameter int RET_W = 32
);
  logic [N-1:0]       cli_req;
  logic [N*ARG_W-1:0] cli_arg;
  logic [N-1:0]       cli_busy;
  logic [N-1:0]       cli_done;
  logic [RET_W-1:0]   cli_return;
  logic               cli_timeout;
  logic               m_req;
  logic [ARG_W-1:0]   m_arg;
  logic               m_busy;
  logic [RET_W-1:0]   m_return;

  modport slave (
    input  cli_req, cli_arg, m_busy, m_return,
    output cli_busy, cli_done, cli_return, cli_timeout, m_req, m_arg
  );

  modport master (
    output cli_req, cli_arg, m_busy, m_return,
    input  cli_busy, cli_done, cli_return, cli_timeout, m_req, m_arg
  );
endinterface

// File: rtl/method_call_arbiter.sv
// method_call_arbiter: shares one method port among N clients.
// Each client pulses cli_req with its argument; the request is buffered (depth 1),
// clients are granted round-robin, the downstream req/busy handshake is run, and
// the result comes back on cli_return with a one-cycle cli_done pulse.
// Ports:
//   clk, reset : single clock, synchronous active-high reset
//   bus        : method_call_arbiter_if.slave (client side cli_*, downstream m_*)
// Optional: define METHOD_ARB_TIMEOUT_EN to bound the downstream wait to TIMEOUT
// cycles; an expired call completes with cli_timeout=1 and cli_return=0.
module method_call_arbiter #(
  parameter int N       = 4,
  parameter int ARG_W   = 32,
  parameter int RET_W   = 32,
  parameter int TIMEOUT = 1000000
) (
  input logic                  clk,
  input logic                  reset,
  method_call_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("method_call_arbiter: N must be 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_tmo
    $error("method_call_arbiter: TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           last_q, last_d, gnt_q, gnt_d;
  logic [N-1:0]            pend_q, pend_d, busy_q, busy_d, done_q, done_d;
  logic [N-1:0][ARG_W-1:0] arg_q, arg_d;
  logic [ARG_W-1:0]        m_arg_q, m_arg_d;
  logic [RET_W-1:0]        ret_q, ret_d;
  logic                    m_req_q, m_req_d;
  logic [IW-1:0]           win, idx;
  logic                    win_vld;
  logic                    expired;

`ifdef METHOD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  // Cleared while issuing so the first WAIT_ACK cycle sees 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE)                          cnt_d = '0;
    else if (state_q inside {WAIT_ACK, WAIT_DONE}) cnt_d = cnt_q + 1'b1;
  end
  assign expired         = (state_q inside {WAIT_ACK, WAIT_DONE}) && (cnt_q == CW'(TIMEOUT));
  assign tmo_d           = expired;
  assign bus.cli_timeout = tmo_q;
`else
  assign expired         = 1'b0;
  assign bus.cli_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    pend_d  = pend_q;
    arg_d   = arg_q;
    m_arg_d = m_arg_q;
    ret_d   = '0;
    m_req_d = 1'b0;
    done_d  = '0;
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;

    // Round-robin scan starting just after the last grant.
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_q) + k) % N);
      if (!win_vld && pend_q[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end

    // Depth-1 buffer per client; busy clients' pulses are dropped.
    for (int i = 0; i < N; i++) begin
      if (bus.cli_req[i] && !busy_q[i]) begin
        pend_d[i] = 1'b1;
        arg_d[i]  = bus.cli_arg[i*ARG_W +: ARG_W];
      end
    end

    case (state_q)
      IDLE: if (win_vld) begin
        state_d     = ISSUE;
        m_req_d     = 1'b1;
        m_arg_d     = arg_q[win];
        pend_d[win] = 1'b0;
        last_d      = win;
        gnt_d       = win;
      end
      ISSUE:     state_d = WAIT_ACK;
      WAIT_ACK:  if (expired) state_d = RESP;
                 else if (bus.m_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (expired) state_d = RESP;
                 else if (!bus.m_busy) begin
                   state_d = RESP;
                   ret_d   = bus.m_return;
                 end
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (state_d == RESP) done_d[gnt_q] = 1'b1;

    // Granted client stays busy until its RESP cycle, where it may re-request.
    busy_d = pend_d;
    if (state_d inside {ISSUE, WAIT_ACK, WAIT_DONE}) busy_d[gnt_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IW'(N - 1);
      gnt_q   <= '0;
      pend_q  <= '0;
      arg_q   <= '0;
      m_arg_q <= '0;
      ret_q   <= '0;
      m_req_q <= 1'b0;
      busy_q  <= '0;
      done_q  <= '0;
`ifdef METHOD_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      pend_q  <= pend_d;
      arg_q   <= arg_d;
      m_arg_q <= m_arg_d;
      ret_q   <= ret_d;
      m_req_q <= m_req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef METHOD_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.m_req      = m_req_q;
  assign bus.m_arg      = m_arg_q;
  assign bus.cli_busy   = busy_q;
  assign bus.cli_done   = done_q;
  assign bus.cli_return = ret_q;
endmodule
